// File: rtl/fft_pkg.sv
// Shared constants, drain state encoding and the index bit-reversal helper.
// The FFT core uses the same bitrev() for its twiddle and address logic.
package fft_pkg;

    localparam int DATA_W   = 16;
    localparam int N_POINTS = 16;
    localparam int LOG2_N   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // Mirror the index bits: bit i of the result is bit LOG2_N-1-i of idx.
    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] idx);
        logic [LOG2_N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = idx[LOG2_N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rate_strobe_gen.sv
// Rising-edge detector for the divided-rate bit, which arrives as plain data
// in the system clock domain. The history register resets high so that a rate
// bit already high when reset is released does not look like an edge.
module rate_strobe_gen (
    input  logic clk,
    input  logic rst,
    input  logic rate_clk,
    output logic strobe
);

    logic rate_d;

    // Delayed copy of the rate bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_d <= 1'b1;
        end else begin
            rate_d <= rate_clk;
        end
    end

    assign strobe = rate_clk & ~rate_d;

endmodule

// File: rtl/fft_sample_framer.sv
// Captures one sample per divided-rate edge into a two-bank frame buffer and
// streams each complete frame to the FFT core over valid/ready, optionally in
// bit-reversed index order.
//
//   state | meaning
//   IDLE  | no beat offered; waiting for the read bank to be full
//   DRAIN | offering beat rd_idx of the read bank; advances on i_ready
module fft_sample_framer
    import fft_pkg::*;
#(
    parameter int DATA_W      = fft_pkg::DATA_W,
    parameter int N_POINTS    = fft_pkg::N_POINTS,
    parameter int LOG2_N      = fft_pkg::LOG2_N,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rate_clk,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [LOG2_N-1:0] o_index,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_overflow
);

    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);

    logic                strobe;
    logic [DATA_W-1:0]   frame_buf [2*N_POINTS];
    logic                wr_bank;
    logic                rd_bank;
    logic [LOG2_N-1:0]   wr_idx;
    logic [LOG2_N-1:0]   rd_idx;
    logic [LOG2_N-1:0]   rd_addr;
    logic [1:0]          full;
    drain_state_t        state;
    drain_state_t        state_next;
    logic                capture;
    logic                frame_done;
    logic                beat;
    logic                last_beat;

    rate_strobe_gen u_rate_strobe (
        .clk      (i_clk),
        .rst      (i_rst),
        .rate_clk (i_rate_clk),
        .strobe   (strobe)
    );

    // A strobe into a full write bank is dropped; the banks never coincide
    // while both hold data, so set and clear of full[] never hit the same bit.
    assign capture    = strobe & ~full[wr_bank];
    assign frame_done = capture & (wr_idx == LAST_IDX);
    assign beat       = (state == DRAIN) & i_ready;
    assign last_beat  = beat & (rd_idx == LAST_IDX);
    assign rd_addr    = BIT_REVERSE ? bitrev(rd_idx) : rd_idx;

    // Sample storage: write port only, read asynchronously below.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            frame_buf[{wr_bank, wr_idx}] <= i_sample;
        end
    end

    // Write pointer, bank select and sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (capture) begin
                wr_idx <= wr_idx + 1'b1;
                if (frame_done) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (strobe & full[wr_bank]) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Bank-full flags: set by the writer, cleared by the last drained beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full <= 2'b00;
        end else begin
            if (last_beat) begin
                full[rd_bank] <= 1'b0;
            end
            if (frame_done) begin
                full[wr_bank] <= 1'b1;
            end
        end
    end

    // Drain state register with read pointer and read bank.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_idx  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                rd_idx <= '0;
            end else if (beat) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (last_beat) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Drain next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (full[rd_bank]) state_next = DRAIN;
            DRAIN:   if (last_beat)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on i_ready.
    assign o_valid = (state == DRAIN);
    assign o_last  = (state == DRAIN) & (rd_idx == LAST_IDX);
    assign o_index = rd_addr;
    assign o_data  = frame_buf[{rd_bank, rd_addr}];

endmodule

// File: tb/tb_fft_sample_framer.sv
// Bench for fft_sample_framer: a natural-order and a bit-reversed instance
// share all inputs. A frame-level queue model predicts every cycle's outputs;
// directed sequences cover latency, overflow, reset and the held rate bit.
module tb_fft_sample_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rate;
    logic [15:0] sample;
    logic        ready;

    logic [15:0] d_nat, d_rev;
    logic [3:0]  x_nat, x_rev;
    logic        v_nat, v_rev, l_nat, l_rev, ov_nat, ov_rev;

    always #5 clk = ~clk;

    fft_sample_framer #(.BIT_REVERSE(1'b0)) dut_nat (
        .i_clk(clk), .i_rst(rst), .i_rate_clk(rate), .i_sample(sample), .i_ready(ready),
        .o_data(d_nat), .o_index(x_nat), .o_valid(v_nat), .o_last(l_nat), .o_overflow(ov_nat)
    );

    fft_sample_framer #(.BIT_REVERSE(1'b1)) dut_rev (
        .i_clk(clk), .i_rst(rst), .i_rate_clk(rate), .i_sample(sample), .i_ready(ready),
        .o_data(d_rev), .o_index(x_rev), .o_valid(v_rev), .o_last(l_rev), .o_overflow(ov_rev)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int rev4(input int p);
        int r = 0;
        for (int i = 0; i < 4; i++) if ((p >> i) & 1) r |= 1 << (3 - i);
        return r;
    endfunction

    // Reference model: frames as queues of samples. m_pend holds completed
    // frames back to back (oldest first); m_part is the frame being filled.
    bit          model_en    = 1'b0;
    bit          m_rate_prev = 1'b1;
    logic [15:0] m_pend[$];
    logic [15:0] m_part[$];
    bit          m_active    = 1'b0;
    int          m_pos       = 0;
    bit          m_ovf       = 1'b0;

    always @(negedge clk) begin
        int nf;
        bit stb;
        bit pop;
        int a_n;
        int a_r;
        if (model_en) begin
            chk("m_valid_nat", v_nat, m_active);
            chk("m_valid_rev", v_rev, m_active);
            chk("m_ovf_nat", ov_nat, m_ovf);
            chk("m_ovf_rev", ov_rev, m_ovf);
            if (m_active) begin
                a_n = m_pos;
                a_r = rev4(m_pos);
                chk("m_data_nat", d_nat, m_pend[a_n]);
                chk("m_index_nat", x_nat, a_n);
                chk("m_last_nat", l_nat, m_pos == 15);
                chk("m_data_rev", d_rev, m_pend[a_r]);
                chk("m_index_rev", x_rev, a_r);
                chk("m_last_rev", l_rev, m_pos == 15);
            end
            if (rst) begin
                m_pend.delete();
                m_part.delete();
                m_active = 1'b0;
                m_pos    = 0;
                m_ovf    = 1'b0;
            end else begin
                nf  = m_pend.size() / 16;
                stb = rate && !m_rate_prev;
                pop = 1'b0;
                if (m_active) begin
                    if (ready) begin
                        m_pos++;
                        if (m_pos == 16) begin
                            pop      = 1'b1;
                            m_active = 1'b0;
                            m_pos    = 0;
                        end
                    end
                end else if (nf > 0) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                end
                if (stb) begin
                    if (nf == 2) m_ovf = 1'b1;
                    else begin
                        m_part.push_back(sample);
                        if (m_part.size() == 16) begin
                            foreach (m_part[i]) m_pend.push_back(m_part[i]);
                            m_part.delete();
                        end
                    end
                end
                if (pop) for (int i = 0; i < 16; i++) void'(m_pend.pop_front());
            end
            m_rate_prev = rst ? 1'b1 : rate;
        end
    end

    // One cycle of stimulus; returns at the following negedge for checking.
    task automatic drive(input bit r, input bit rc, input logic [15:0] s, input bit rd);
        @(posedge clk);
        #1;
        rst    = r;
        rate   = rc;
        sample = s;
        ready  = rd;
        @(negedge clk);
    endtask

    task automatic strobes(input int base, input int n, input bit rd);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 16'(base + i), rd);
            drive(1'b0, 1'b0, 16'h0, rd);
        end
    endtask

    task automatic collect(input string name, input int base, input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1);
            if (v_nat) begin
                chk(name, d_nat, base + got);
                got++;
            end
        end
        chk({name, "_count"}, got, n);
    endtask

    typedef struct {
        logic [15:0] nat;
        logic [15:0] rev;
        bit          last;
    } vec_t;

    vec_t tbl[16];
    int   rev_lit[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    initial begin
        int sc;
        int got;
        bit rc;
        bit rd;

        for (int b = 0; b < 16; b++) begin
            tbl[b].nat  = 16'(b);
            tbl[b].rev  = 16'(rev_lit[b]);
            tbl[b].last = (b == 15);
        end

        rst = 1'b1; rate = 1'b0; sample = 16'h0; ready = 1'b0;
        repeat (2) @(posedge clk);
        model_en = 1'b1;
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        chk("reset_valid", v_nat, 0);
        chk("reset_overflow", ov_nat, 0);

        // Frame of 0..15 with ready high: latency and beat order for both instances.
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        strobes(0, 16, 1'b1);
        chk("t1_no_valid_T+1", v_nat, 0);
        for (int b = 0; b < 16; b++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1);
            chk("t1_valid_nat", v_nat, 1);
            chk("t1_data_nat", d_nat, tbl[b].nat);
            chk("t1_index_nat", x_nat, tbl[b].nat);
            chk("t1_last_nat", l_nat, tbl[b].last);
            chk("t2_valid_rev", v_rev, 1);
            chk("t2_data_rev", d_rev, tbl[b].rev);
            chk("t2_index_rev", x_rev, tbl[b].rev);
            chk("t2_last_rev", l_rev, tbl[b].last);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t1_idle_after_frame", v_nat, 0);

        // Divide-by-2 rate bit with ready toggling every cycle.
        sc  = 0;
        got = 0;
        for (int c = 0; c < 300 && got < 32; c++) begin
            rc = (c % 2 == 1) && (sc < 32);
            rd = (c % 2 == 0);
            drive(1'b0, rc, rc ? 16'(sc) : 16'h0, rd);
            if (rc) sc++;
            if (v_nat && rd) begin
                chk("t3_order", d_nat, got);
                got++;
            end
        end
        chk("t3_count", got, 32);
        chk("t3_no_overflow", ov_nat, 0);

        // Both banks full with ready low: the 33rd sample is dropped.
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        strobes(0, 33, 1'b0);
        chk("t4_overflow_set", ov_nat, 1);
        collect("t4_frames", 0, 32, 80);
        chk("t4_overflow_held", ov_nat, 1);

        // Reset in a partial frame and again mid-drain.
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        strobes(300, 7, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t5_valid_after_rst1", v_nat, 0);
        strobes(400, 16, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t5_mid_drain", v_nat, 1);
        drive(1'b1, 1'b0, 16'h0, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t5_valid_after_rst2", v_nat, 0);
        chk("t5_overflow_clear", ov_nat, 0);
        strobes(100, 16, 1'b0);
        collect("t5_clean", 100, 16, 40);

        // Rate bit held high through reset release: no capture until a real edge.
        drive(1'b1, 1'b1, 16'h0, 1'b0);
        drive(1'b1, 1'b1, 16'h0, 1'b0);
        repeat (4) drive(1'b0, 1'b1, 16'd77, 1'b0);
        chk("t6_no_frame", v_nat, 0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        strobes(50, 16, 1'b0);
        collect("t6_frame", 50, 16, 40);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
                  16'($urandom), $urandom_range(0, 3) != 0);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
